// File: rtl/ii_rect_sum.sv
// Rectangle sum over an integral image buffer.
// Reads up to four corners and folds them as D - B - C + A.
module ii_rect_sum #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [7:0]        x1,
  input  logic [6:0]        y0,
  input  logic [6:0]        y1,
  output logic              busy,
  output logic [14:0]       rd_addr,
  input  logic [DATA_W-1:0] ii_rddata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rect_sum
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic v;
    logic neg;
    logic last;
  } tag_t;

  state_t state, state_nx;

  logic [7:0]        lx0, lx1;
  logic [6:0]        ly0, ly1;
  logic [3:0]        pend, sel, pend_nx;
  logic              bad, inval, last_iss;
  logic              ld_addr, acc_clr, fin;
  logic [7:0]        xs;
  logic [6:0]        ys;
  logic [14:0]       addr_nx;
  logic [DATA_W-1:0] acc;
  tag_t              pipe [RD_LAT+1];
  tag_t              ret;

  assign inval = (x1 < x0) || (y1 < y0)
              || (32'(x1) >= 32'(IMG_W))
              || (32'(y1) >= 32'(IMG_H));

  // pend bits: 0=D 1=B 2=C 3=A; lowest set bit issues next
  assign sel      = pend & (~pend + 4'd1);
  assign pend_nx  = pend & ~sel;
  assign last_iss = (pend_nx == 4'd0);

  assign xs = (sel[1] | sel[3]) ? lx0 - 8'd1 : lx1;
  assign ys = (sel[2] | sel[3]) ? ly0 - 7'd1 : ly1;

  assign addr_nx = 15'(32'(ys) * 32'(IMG_W) + 32'(xs));
  assign ret     = pipe[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = inval ? DONE : ISSUE;
      ISSUE: if (last_iss) state_nx = DRAIN;
      DRAIN: if (ret.v && ret.last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_addr = 1'b0;
    acc_clr = 1'b0;
    fin     = 1'b0;
    unique case (1'b1)
      (state == IDLE):  acc_clr = start;
      (state == ISSUE): ld_addr = 1'b1;
      (state == DONE):  fin     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx0      <= '0;
      lx1      <= '0;
      ly0      <= '0;
      ly1      <= '0;
      pend     <= '0;
      bad      <= 1'b0;
      busy     <= 1'b0;
      rd_addr  <= '0;
      acc      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rect_sum <= '0;
      for (int i = 0; i <= RD_LAT; i++)
        pipe[i] <= '0;
    end else begin
      if (acc_clr) begin
        lx0  <= x0;
        lx1  <= x1;
        ly0  <= y0;
        ly1  <= y1;
        pend <= {(x0 != 8'd0) && (y0 != 7'd0),
                 y0 != 7'd0, x0 != 8'd0, 1'b1};
        bad  <= inval;
        busy <= 1'b1;
      end else if (ld_addr) begin
        pend <= pend_nx;
      end

      if (ld_addr)
        rd_addr <= addr_nx;

      // tags travel alongside the read so data lines up with its sign
      pipe[0] <= {ld_addr, sel[1] | sel[2], last_iss};
      for (int i = 1; i <= RD_LAT; i++)
        pipe[i] <= pipe[i-1];

      if (acc_clr)
        acc <= '0;
      else if (ret.v)
        acc <= ret.neg ? acc - ii_rddata : acc + ii_rddata;

      done <= fin;
      err  <= fin & bad;
      if (fin) begin
        rect_sum <= acc;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ii_rect_sum.sv
// Bench for ii_rect_sum: directed table on a ones image plus
// random rectangles, checked on RD_LAT=1 and RD_LAT=2 instances.
module tb_ii_rect_sum;

  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  x0, x1;
  logic [6:0]  y0, y1;
  logic        busy1, done1, err1;
  logic        busy2, done2, err2;
  logic [14:0] ra1, ra2;
  logic [31:0] rd1, rd2, sum1, sum2;
  logic [31:0] r1, r2a, r2b;

  logic [31:0] mem [0:32767];
  logic [7:0]  pix [0:H-1][0:W-1];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1  <= mem[ra1];
    r2a <= mem[ra2];
    r2b <= r2a;
  end
  assign rd1 = r1;
  assign rd2 = r2b;

  ii_rect_sum #(.IMG_W(W), .IMG_H(H), .DATA_W(32), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .busy(busy1), .rd_addr(ra1), .ii_rddata(rd1),
    .done(done1), .err(err1), .rect_sum(sum1)
  );

  ii_rect_sum #(.IMG_W(W), .IMG_H(H), .DATA_W(32), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .busy(busy2), .rd_addr(ra2), .ii_rddata(rd2),
    .done(done2), .err(err2), .rect_sum(sum2)
  );

  typedef struct {
    int              first_done;
    int              ndone;
    logic [31:0]     sum;
    logic            err;
    logic [3:0][14:0] addr;
    logic            busy_c0;
    logic            busy_end;
    logic [31:0]     sum_end;
    logic [14:0]     addr_c0;
  } res_t;

  typedef struct {
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [31:0] sum;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic build_image(input bit rnd);
    for (int i = 0; i < 32768; i++) mem[i] = 32'd0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix[y][x] = rnd ? 8'($urandom) : 8'd1;
    // II(x,y) = sum of pix over [0..x]x[0..y]
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [31:0] v;
        v = 32'(pix[y][x]);
        if (x > 0) v += mem[y*W + x - 1];
        if (y > 0) v += mem[(y-1)*W + x];
        if (x > 0 && y > 0) v -= mem[(y-1)*W + x - 1];
        mem[y*W + x] = v;
      end
  endtask

  function automatic logic [31:0] ref_sum(input int a0, a1, b0, b1);
    logic [31:0] s = 0;
    for (int y = b0; y <= b1; y++)
      for (int x = a0; x <= a1; x++)
        s += 32'(pix[y][x]);
    return s;
  endfunction

  task automatic run_req(input logic [7:0] a0, a1,
                         input logic [6:0] b0, b1,
                         input bit repulse,
                         output res_t q1, output res_t q2);
    q1.first_done = -1; q2.first_done = -1;
    q1.ndone = 0;       q2.ndone = 0;
    q1.sum = '0;        q2.sum = '0;
    q1.err = 1'b0;      q2.err = 1'b0;
    q1.addr = '0;       q2.addr = '0;
    q1.addr_c0 = ra1;   q2.addr_c0 = ra2;
    start = 1'b1;
    x0 = a0; x1 = a1; y0 = b0; y1 = b1;
    @(negedge clk);
    start = 1'b0;
    q1.busy_c0 = busy1;
    q2.busy_c0 = busy2;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        q1.addr[c-1] = ra1;
        q2.addr[c-1] = ra2;
      end
      if (done1) begin
        if (q1.first_done < 0) begin
          q1.first_done = c; q1.sum = sum1; q1.err = err1;
        end
        q1.ndone++;
      end
      if (done2) begin
        if (q2.first_done < 0) begin
          q2.first_done = c; q2.sum = sum2; q2.err = err2;
        end
        q2.ndone++;
      end
      if (repulse && c == 2) begin
        start = 1'b1;
        x0 = 8'd0; x1 = 8'd0; y0 = 7'd0; y1 = 7'd0;
      end
      if (c == 3) start = 1'b0;
    end
    q1.busy_end = busy1; q2.busy_end = busy2;
    q1.sum_end  = sum1;  q2.sum_end  = sum2;
  endtask

  task automatic verify(input string tg,
                        input logic [7:0] a0, a1,
                        input logic [6:0] b0, b1,
                        input logic [31:0] es, input logic ee,
                        input res_t q, input int lat);
    int n;
    logic [14:0] ea [4];
    n = 0;
    ea[n++] = 15'(int'(b1) * W + int'(a1));
    if (a0 != 0) ea[n++] = 15'(int'(b1) * W + int'(a0) - 1);
    if (b0 != 0) ea[n++] = 15'((int'(b0) - 1) * W + int'(a1));
    if (a0 != 0 && b0 != 0)
      ea[n++] = 15'((int'(b0) - 1) * W + int'(a0) - 1);
    chk({tg, "_ndone"}, q.ndone, 1);
    chk({tg, "_sum"}, q.sum, es);
    chk({tg, "_err"}, q.err, ee);
    chk({tg, "_busy"}, q.busy_c0, 1);
    chk({tg, "_idle"}, q.busy_end, 0);
    chk({tg, "_hold"}, q.sum_end, es);
    if (!ee) begin
      chk({tg, "_lat"}, q.first_done, 2 + n + lat);
      for (int j = 0; j < 4; j++)
        chk({tg, "_addr"}, q.addr[j], j < n ? ea[j] : ea[n-1]);
    end else begin
      chk({tg, "_dseen"}, q.first_done > 0, 1);
      for (int j = 0; j < 4; j++)
        chk({tg, "_noaddr"}, q.addr[j], q.addr_c0);
    end
  endtask

  initial begin
    vec_t tbl [10];
    res_t q1, q2;
    int   nd;

    tbl[0] = '{10,  19,  5,   14,  100,   0};
    tbl[1] = '{0,   159, 0,   119, 19200, 0};
    tbl[2] = '{0,   3,   2,   2,   4,     0};
    tbl[3] = '{20,  10,  0,   0,   0,     1};
    tbl[4] = '{5,   5,   0,   9,   10,    0};
    tbl[5] = '{159, 159, 119, 119, 1,     0};
    tbl[6] = '{0,   200, 0,   0,   0,     1};
    tbl[7] = '{0,   0,   0,   120, 0,     1};
    tbl[8] = '{3,   3,   5,   4,   0,     1};
    tbl[9] = '{0,   159, 119, 119, 160,   0};

    rst_n = 1'b0;
    start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    build_image(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy1, busy2}, 0);
    chk("rst_done", {done1, done2}, 0);
    chk("rst_err", {err1, err2}, 0);
    chk("rst_addr", {ra1, ra2}, 0);
    chk("rst_sum", {sum1, sum2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_req(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, 1'b0, q1, q2);
      verify($sformatf("t%0d_l1", i), tbl[i].x0, tbl[i].x1,
             tbl[i].y0, tbl[i].y1, tbl[i].sum, tbl[i].err, q1, 1);
      verify($sformatf("t%0d_l2", i), tbl[i].x0, tbl[i].x1,
             tbl[i].y0, tbl[i].y1, tbl[i].sum, tbl[i].err, q2, 2);
    end

    // second start while busy must be dropped
    run_req(10, 19, 5, 14, 1'b1, q1, q2);
    verify("rep_l1", 10, 19, 5, 14, 100, 0, q1, 1);
    verify("rep_l2", 10, 19, 5, 14, 100, 0, q2, 2);

    // reset during ISSUE
    start = 1'b1;
    x0 = 10; x1 = 19; y0 = 5; y1 = 14;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {busy1, busy2}, 0);
    chk("mrst_done", {done1, done2}, 0);
    chk("mrst_err", {err1, err2}, 0);
    chk("mrst_addr", {ra1, ra2}, 0);
    chk("mrst_sum", {sum1, sum2}, 0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      nd += int'(done1) + int'(done2);
    end
    rst_n = 1'b1;
    run_req(0, 3, 2, 2, 1'b0, q1, q2);
    chk("mrst_nodone", nd, 0);
    verify("post_l1", 0, 3, 2, 2, 4, 0, q1, 1);
    verify("post_l2", 0, 3, 2, 2, 4, 0, q2, 2);

    build_image(1'b1);
    for (int i = 0; i < 1000; i++) begin
      int a0, a1, b0, b1;
      logic [31:0] es;
      a0 = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, W-1);
      a1 = $urandom_range(a0, W-1);
      b0 = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, H-1);
      b1 = $urandom_range(b0, H-1);
      es = ref_sum(a0, a1, b0, b1);
      run_req(8'(a0), 8'(a1), 7'(b0), 7'(b1), 1'b0, q1, q2);
      verify($sformatf("r%0d_l1", i), 8'(a0), 8'(a1), 7'(b0),
             7'(b1), es, 1'b0, q1, 1);
      verify($sformatf("r%0d_l2", i), 8'(a0), 8'(a1), 7'(b0),
             7'(b1), es, 1'b0, q2, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
